// File: rtl/add_scheduler_if.sv
// rtl/add_scheduler_if.sv - request, shared-adder and response signals of add_scheduler
interface add_scheduler_if #(
  parameter int W = 8
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;
  logic [W-1:0] add_num1;
  logic [W-1:0] add_num2;
  logic [W:0]   add_sout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W:0]   rsp_sum;

  // scheduler side
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, add_sout, rsp_ready,
    output req_ready, add_num1, add_num2, rsp_valid, rsp_id, rsp_sum
  );

  // clients plus adder side
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, add_sout, rsp_ready,
    input  req_ready, add_num1, add_num2, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/add_scheduler.sv
// rtl/add_scheduler.sv - round-robin sharing of one adder between two requesters
module add_scheduler #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  add_scheduler_if.slave bus,
  output logic           busy,
  output logic [7:0]     carry_count
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last_id;
  logic       grant_valid;
  logic       grant_id;
  logic [1:0] ready_vec;
  logic       accept;
  logic       rsp_hs;

  // Ties go to whoever was not served last, so back-to-back contention alternates.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    case (bus.req_valid)
      2'b01: begin grant_valid = 1'b1; grant_id = 1'b0;     end
      2'b10: begin grant_valid = 1'b1; grant_id = 1'b1;     end
      2'b11: begin grant_valid = 1'b1; grant_id = ~last_id; end
      default: ;
    endcase
  end

  always_comb begin
    ready_vec = 2'b00;
    if (state == IDLE && grant_valid && rst_n)
      ready_vec[grant_id] = 1'b1;
  end

  assign bus.req_ready = ready_vec;
  assign accept        = |(bus.req_valid & ready_vec);
  assign rsp_hs        = (state == RESP) && bus.rsp_ready;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.add_num1  <= '0;
      bus.add_num2  <= '0;
      bus.rsp_sum   <= '0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      last_id       <= 1'b1;
      carry_count   <= 8'd0;
    end else begin
      if (accept) begin
        bus.add_num1 <= grant_id ? bus.req_a1 : bus.req_a0;
        bus.add_num2 <= grant_id ? bus.req_b1 : bus.req_b0;
        bus.rsp_id   <= grant_id;
        last_id      <= grant_id;
      end
      if (state == CALC) begin
        bus.rsp_sum   <= bus.add_sout;
        bus.rsp_valid <= 1'b1;
      end
      if (rsp_hs) begin
        bus.rsp_valid <= 1'b0;
        // Only completed handshakes count, and the counter sticks at its ceiling.
        if (bus.rsp_sum[W] && carry_count != 8'hFF)
          carry_count <= carry_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_add_scheduler.sv
// tb/tb_add_scheduler.sv - directed self-checking bench for add_scheduler
module tb_add_scheduler;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] carry_count;
  int         n_checks = 0;
  int         n_fail = 0;

  add_scheduler_if #(.W(W)) bus ();

  add_scheduler #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .carry_count (carry_count)
  );

  // behavioural stand-in for the shared adder
  assign bus.add_sout = {1'b0, bus.add_num1} + {1'b0, bus.add_num2};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_a0    = '0;
    bus.req_b0    = '0;
    bus.req_a1    = '0;
    bus.req_b1    = '0;
    bus.rsp_ready = 1'b0;
    tick();
    chk("reset_req_ready", 32'(bus.req_ready), 'h0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 'h0);
    chk("reset_busy", 32'(busy), 'h0);
    chk("reset_carry", 32'(carry_count), 'h0);
    chk("reset_num1", 32'(bus.add_num1), 'h0);
    chk("reset_sum", 32'(bus.rsp_sum), 'h0);
    tick();
    rst_n = 1'b1;

    // single request from requester 0
    bus.req_valid = 2'b01; bus.req_a0 = 8'h80; bus.req_b0 = 8'h01; bus.rsp_ready = 1'b1;
    #1;
    chk("single_ready", 32'(bus.req_ready), 'h1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("single_calc_busy", 32'(busy), 'h1);
    chk("single_calc_valid", 32'(bus.rsp_valid), 'h0);
    chk("single_calc_ready", 32'(bus.req_ready), 'h0);
    chk("single_num1", 32'(bus.add_num1), 'h80);
    chk("single_num2", 32'(bus.add_num2), 'h01);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 'h1);
    chk("single_rsp_sum", 32'(bus.rsp_sum), 'h081);
    chk("single_rsp_id", 32'(bus.rsp_id), 'h0);
    tick();
    chk("single_done_valid", 32'(bus.rsp_valid), 'h0);
    chk("single_done_busy", 32'(busy), 'h0);
    chk("single_carry", 32'(carry_count), 'h0);

    // carry-producing request from requester 1
    bus.req_valid = 2'b10; bus.req_a1 = 8'h80; bus.req_b1 = 8'h80;
    #1;
    chk("carry_ready", 32'(bus.req_ready), 'h2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("carry_rsp_sum", 32'(bus.rsp_sum), 'h100);
    chk("carry_rsp_id", 32'(bus.rsp_id), 'h1);
    chk("carry_before_hs", 32'(carry_count), 'h0);
    tick();
    chk("carry_after_hs", 32'(carry_count), 'h1);

    // tie right after reset: 0,1,0 with 3-cycle spacing
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_a0 = 8'h40; bus.req_b0 = 8'h80;
    bus.req_a1 = 8'h40; bus.req_b1 = 8'h20;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("tie_ready", 32'(bus.req_ready), (k % 2 == 0) ? 'h1 : 'h2);
      tick();
      tick();
      chk("tie_rsp_valid", 32'(bus.rsp_valid), 'h1);
      chk("tie_rsp_sum", 32'(bus.rsp_sum), (k % 2 == 0) ? 'h0C0 : 'h060);
      chk("tie_rsp_id", 32'(bus.rsp_id), (k % 2 == 0) ? 'h0 : 'h1);
      tick();
    end
    bus.req_valid = 2'b00;

    // backpressure with requester 1 waiting
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01; bus.req_a0 = 8'h12; bus.req_b0 = 8'h34;
    #1;
    chk("bp_ready", 32'(bus.req_ready), 'h1);
    tick();
    bus.req_valid = 2'b10;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 'h1);
      chk("bp_rsp_sum", 32'(bus.rsp_sum), 'h046);
      chk("bp_rsp_id", 32'(bus.rsp_id), 'h0);
      chk("bp_req_ready", 32'(bus.req_ready), 'h0);
      chk("bp_busy", 32'(busy), 'h1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_busy", 32'(busy), 'h1);
    tick();
    chk("bp_idle_busy", 32'(busy), 'h0);
    chk("bp_idle_valid", 32'(bus.rsp_valid), 'h0);
    chk("bp_waiter_ready", 32'(bus.req_ready), 'h2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("bp_waiter_sum", 32'(bus.rsp_sum), 'h060);
    chk("bp_waiter_id", 32'(bus.rsp_id), 'h1);
    tick();

    // asynchronous reset while in CALC
    bus.req_valid = 2'b01; bus.req_a0 = 8'hFF; bus.req_b0 = 8'h01;
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("midrst_in_calc", 32'(busy), 'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 'h0);
    chk("midrst_valid", 32'(bus.rsp_valid), 'h0);
    chk("midrst_ready", 32'(bus.req_ready), 'h0);
    chk("midrst_num1", 32'(bus.add_num1), 'h0);
    chk("midrst_sum", 32'(bus.rsp_sum), 'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 'h0);
    end
    bus.req_valid = 2'b11;
    bus.req_a1 = 8'h01; bus.req_b1 = 8'h01;
    #1;
    chk("midrst_first_grant", 32'(bus.req_ready), 'h1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("midrst_rsp_sum", 32'(bus.rsp_sum), 'h100);
    chk("midrst_rsp_id", 32'(bus.rsp_id), 'h0);
    tick();
    chk("midrst_carry", 32'(carry_count), 'h1);

    // saturation: 260 more carry results on top of the one above
    bus.req_valid = 2'b01; bus.req_a0 = 8'hFF; bus.req_b0 = 8'h01;
    for (int j = 1; j <= 260; j++) begin
      tick();
      tick();
      tick();
      if (j == 253)
        chk("sat_254", 32'(carry_count), 'd254);
      if (j == 254)
        chk("sat_255", 32'(carry_count), 'd255);
    end
    bus.req_valid = 2'b00;
    tick();
    chk("sat_hold", 32'(carry_count), 'd255);
    chk("sat_idle", 32'(busy), 'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
